// File: rtl/rs232_rxb_if.sv
// rs232_rxb_if: serial-line and CPU-side FIFO signals of the buffered RS232
// receiver.
//   fsel     : baud select, 0 = 19200, 1 = 115200
//   rxd      : asynchronous serial line, idle high
//   rd       : pop the FIFO head (ignored when empty)
//   clr      : clear the sticky error flags
//   data_out : FIFO head byte, 8'h00 when empty
//   empty    : FIFO holds no bytes
//   full     : FIFO holds num_slots bytes
//   ovr_err  : sticky, a valid byte was dropped on a full FIFO
//   frm_err  : sticky, a frame ended with a low stop bit
// master = CPU glue / line driver side, slave = receiver side.
`timescale 1ns/1ps
interface rs232_rxb_if;
    logic       fsel;
    logic       rxd;
    logic       rd;
    logic       clr;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       ovr_err;
    logic       frm_err;

    modport master (
        output fsel, rxd, rd, clr,
        input  data_out, empty, full, ovr_err, frm_err
    );

    modport slave (
        input  fsel, rxd, rd, clr,
        output data_out, empty, full, ovr_err, frm_err
    );
endinterface

// File: rtl/rs232_rxb.sv
// rs232_rxb: buffered RS232 receiver. Recovers 8N1 frames from rxd, checks
// start and stop bits, and pushes each valid byte into a circular FIFO that
// the CPU glue reads with single-cycle pops (first-word fall-through).
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : rs232_rxb_if.slave (fsel, rxd, rd, clr in; data_out, empty, full,
//         ovr_err, frm_err out)
`timescale 1ns/1ps
module rs232_rxb #(
    parameter int unsigned clock_freq = 50000000,
    parameter int unsigned num_slots  = 63
) (
    input  logic        clk,
    input  logic        rst,
    rs232_rxb_if.slave  bus
);

    localparam int unsigned CW = $clog2(clock_freq / 19200) + 1;
    localparam int unsigned PW = $clog2(num_slots);
    localparam int unsigned NW = $clog2(num_slots + 1);

    localparam logic [CW-1:0] BIT_SLOW = CW'(clock_freq / 19200);
    localparam logic [CW-1:0] BIT_FAST = CW'(clock_freq / 115200);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // ---------------- input synchronizer ----------------
    logic [1:0] sync;
    logic       rxs;
    logic       prev;

    assign rxs = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            prev <= 1'b1;
        end else begin
            sync <= {sync[0], bus.rxd};
            prev <= rxs;
        end
    end

    // ---------------- frame recovery ----------------
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] bit_len;
    logic [CW-1:0] half_len;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          cnt_done;
    logic          push;
    logic          stop_bad;

    assign half_len = bit_len >> 1;

    always_comb begin
        cnt_done = 1'b0;
        if (state == START)
            cnt_done = (cnt == half_len - CW'(1));
        else
            cnt_done = (cnt == bit_len - CW'(1));
    end

    assign push     = (state == STOP) && cnt_done && rxs;
    assign stop_bad = (state == STOP) && cnt_done && !rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_len <= BIT_SLOW;
            idx     <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // a start needs a real 1->0 edge, so a line stuck low
                    // after a framing error is not re-detected as a start
                    if (!rxs && prev) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_len <= bus.fsel ? BIT_FAST : BIT_SLOW;
                    end
                end
                START: begin
                    if (cnt_done) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_done) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt_done) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]    mem [num_slots];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic          is_full;
    logic          is_empty;
    logic          do_rd;
    logic          do_wr;
    logic          ovr_set;

    assign is_full  = (count == NW'(num_slots));
    assign is_empty = (count == '0);
    assign do_rd    = bus.rd && !is_empty;
    // a pop in the same cycle frees the slot the push needs
    assign do_wr    = push && (!is_full || do_rd);
    assign ovr_set  = push && is_full && !do_rd;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(num_slots - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= nxt(wr_ptr);
            if (do_rd)
                rd_ptr <= nxt(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- sticky error flags ----------------
    logic ovr_q;
    logic frm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
            frm_q <= 1'b0;
        end else begin
            // a new error event takes priority over clr
            if (ovr_set)
                ovr_q <= 1'b1;
            else if (bus.clr)
                ovr_q <= 1'b0;
            if (stop_bad)
                frm_q <= 1'b1;
            else if (bus.clr)
                frm_q <= 1'b0;
        end
    end

    assign bus.data_out = is_empty ? 8'h00 : mem[rd_ptr];
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.ovr_err  = ovr_q;
    assign bus.frm_err  = frm_q;

endmodule

// File: doc/rs232_rxb.md
Name: rs232_rxb

Overview:
Buffered RS232 receiver. It recovers 8N1 frames from the serial line, checks each start and stop bit, and pushes each valid byte into an internal FIFO. The CPU-side IO glue reads the FIFO with single-cycle pops. It is the receive counterpart of the buffered transmitter in the same UART device, and shares that device's fsel baud selection.

Parameters:
clock_freq, 50000000, system clock frequency in Hz; used to derive bit timing.
num_slots, 63, FIFO depth in bytes; any integer >= 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
fsel  input  1  baud select: 0 = 19200, 1 = 115200; sampled only at start-bit detection
rxd  input  1  serial line, asynchronous, idle high
rd  input  1  pop FIFO head; ignored when empty
clr  input  1  clear sticky error flags
data_out  output  8  FIFO head byte, first-word fall-through; 8'h00 when empty
empty  output  1  FIFO holds no bytes
full  output  1  FIFO holds num_slots bytes
ovr_err  output  1  sticky: a valid byte was dropped because the FIFO was full
frm_err  output  1  sticky: a frame had a low stop bit

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; the FIFO is emptied.
  - empty=1, full=0, ovr_err=0, frm_err=0, data_out=8'h00.
  - rxd synchronizer flops reset to 1.
  - A reset in mid-frame discards the partial byte.
- Input synchronization: rxd passes through two flops (rxs) before any use.
- Bit timing: bit_cnt = clock_freq/19200 or clock_freq/115200, integer division, latched from fsel on start detection. half_cnt = bit_cnt/2.
  - Cycle counter width: $clog2(clock_freq/19200)+1.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: rxs==0 -> START, counter cleared.
  - START: after half_cnt cycles, sample rxs. If 1, it is a false start: -> IDLE, nothing stored. If 0 -> DATA, counter cleared, bit index 0.
  - DATA: every bit_cnt cycles, sample rxs into shift register, LSB first. After the 8th sample -> STOP.
  - STOP: after bit_cnt cycles, sample rxs.
    - rxs==1: the byte is valid; issue a one-cycle push, then -> IDLE.
    - rxs==0: set frm_err, no push, -> IDLE. The next start is detected only once rxs has returned high and then falls again; IDLE requires a 1->0 edge, tracked by a prev-sample flop.
- Latency: empty deasserts on the clock edge after the stop-bit sample cycle.
- FIFO:
  - Circular buffer with rd/wr pointers that wrap at num_slots-1 -> 0, plus a count register (0..num_slots).
  - Push when full and no rd in the same cycle: byte dropped, ovr_err set, FIFO unchanged.
  - Push and rd in the same cycle while full: both take effect, count unchanged, no overrun.
  - Push and rd in the same cycle while empty: the push is stored and the rd is ignored.
  - rd when empty: no effect, no error.
  - data_out updates combinationally from the head slot after each pop or push.
- clr: clears ovr_err and frm_err on the next edge. If clr coincides with a new error event, the error wins and the flag stays set.
- fsel changes mid-frame have no effect until the next start detection.

Test Plan:
- Byte at 115200, fsel=1, 50 MHz clock (bit_cnt=434): send 8'hA5 -> empty falls about 10*434 cycles after the start edge; data_out=8'hA5; rd pulse -> empty=1.
- Byte at 19200, fsel=0 (bit_cnt=2604): send 8'h3C and 8'hFF back-to-back -> data_out shows 3C, then FF after one rd; ovr_err=0, frm_err=0.
- Glitch: rxd low for 100 cycles, then high -> no push, empty stays 1; a following real frame 8'h01 is received correctly.
- Framing: send 8'h55 with stop bit held low for one bit, then line high -> frm_err=1, empty=1. clr=1 -> frm_err=0.
- Overflow: num_slots=4, send 5 frames 00..04 with no rd -> full=1 after the 4th frame, ovr_err=1 after the 5th; reads return 00,01,02,03, then empty=1.
- Reset mid-frame, plus pointer wrap:
  - Assert rst during the DATA state of 8'h81 -> all outputs at reset values; a following frame 8'h7E is received intact.
  - Push 10 bytes through the 4-slot FIFO, reading each one -> order preserved across pointer wrap.
